// File: rtl/ctrl_pkg.sv
// Shared encodings for the single-cycle RISC-V control block: opcodes,
// immediate formats, writeback sources, ALU decoder classes and ALU operations.
package ctrl_pkg;

    typedef enum logic [6:0] {
        OP_LW    = 7'b0000011,
        OP_SW    = 7'b0100011,
        OP_RTYPE = 7'b0110011,
        OP_BEQ   = 7'b1100011,
        OP_IALU  = 7'b0010011,
        OP_JAL   = 7'b1101111
    } opcode_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

endpackage

// File: rtl/ctrl_alu_dec.sv
// Combinational ALU decoder: turns the main decoder's ALUOp class plus the
// funct fields into a concrete ALU operation.
module alu_dec
    import ctrl_pkg::*;
(
    input  alu_op_e    ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       op5,
    output alu_ctrl_e  ALUControl
);

    // Select the ALU operation; only R-type (op5=1) with funct7 set subtracts.
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD:  ALUControl = ALU_ADD;
            ALUOP_SUB:  ALUControl = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  ALUControl = (op5 && funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default:    ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/ctrl.sv
// Registered main decoder for a single-cycle RISC-V datapath. All outputs
// update one clock after the instruction fields are presented.
// Optional feature: define CTRL_BNE_EN to make funct3=001 on the branch
// opcode (bne) branch on NOT Zero.
module ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    output logic       PCSrc,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl
);

    logic        reg_write_d, alu_src_d, mem_write_d, branch_d, jump_d;
    logic        branch_cond_d, pcsrc_d;
    imm_src_e    imm_src_d;
    result_src_e result_src_d;
    alu_op_e     alu_op_d;
    alu_ctrl_e   alu_ctrl_d;

    logic        pcsrc_q, mem_write_q, alu_src_q, reg_write_q;
    imm_src_e    imm_src_q;
    result_src_e result_src_q;
    alu_ctrl_e   alu_ctrl_q;

    // Main decode; unknown opcodes leave everything at zero so nothing is written.
    always_comb begin
        reg_write_d  = 1'b0;
        imm_src_d    = IMM_I;
        alu_src_d    = 1'b0;
        mem_write_d  = 1'b0;
        result_src_d = RES_ALU;
        branch_d     = 1'b0;
        alu_op_d     = ALUOP_ADD;
        jump_d       = 1'b0;
        case (op)
            OP_LW: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = RES_MEM;
            end
            OP_SW: begin
                imm_src_d    = IMM_S;
                alu_src_d    = 1'b1;
                mem_write_d  = 1'b1;
            end
            OP_RTYPE: begin
                reg_write_d  = 1'b1;
                alu_op_d     = ALUOP_FUNC;
            end
            OP_BEQ: begin
                imm_src_d    = IMM_B;
                branch_d     = 1'b1;
                alu_op_d     = ALUOP_SUB;
            end
            OP_IALU: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                alu_op_d     = ALUOP_FUNC;
            end
            OP_JAL: begin
                reg_write_d  = 1'b1;
                imm_src_d    = IMM_J;
                result_src_d = RES_PC4;
                jump_d       = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch condition and PC redirect.
    always_comb begin
`ifdef CTRL_BNE_EN
        branch_cond_d = (funct3 == 3'b001) ? ~Zero : Zero;
`else
        branch_cond_d = Zero;
`endif
        pcsrc_d = (branch_d & branch_cond_d) | jump_d;
    end

    alu_dec u_alu_dec (
        .ALUOp      (alu_op_d),
        .funct3     (funct3),
        .funct7     (funct7),
        .op5        (op[5]),
        .ALUControl (alu_ctrl_d)
    );

    // Output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcsrc_q      <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            imm_src_q    <= IMM_I;
            result_src_q <= RES_ALU;
            alu_ctrl_q   <= ALU_ADD;
        end else begin
            pcsrc_q      <= pcsrc_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            imm_src_q    <= imm_src_d;
            result_src_q <= result_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
        end
    end

    assign PCSrc      = pcsrc_q;
    assign MemWrite   = mem_write_q;
    assign ALUSrc     = alu_src_q;
    assign RegWrite   = reg_write_q;
    assign ImmSrc     = imm_src_q;
    assign ResultSrc  = result_src_q;
    assign ALUControl = alu_ctrl_q;

endmodule

// File: tb/tb_ctrl.sv
// Directed bench for ctrl. Observed outputs are packed as
// {PCSrc, MemWrite, ALUSrc, RegWrite, ImmSrc[1:0], ResultSrc[1:0], ALUControl[2:0]}
// and compared against hand-computed vectors.
module tb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       Zero;
    logic       PCSrc, MemWrite, ALUSrc, RegWrite;
    logic [1:0] ImmSrc, ResultSrc;
    logic [2:0] ALUControl;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .PCSrc      (PCSrc),
        .MemWrite   (MemWrite),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl)
    );

    function automatic logic [10:0] outs();
        return {PCSrc, MemWrite, ALUSrc, RegWrite, ImmSrc, ResultSrc, ALUControl};
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b required %b", tag, obs, exp);
        end else begin
            $display("ok   %s: %b", tag, obs);
        end
    endtask

    // Present one instruction, clock it in, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic rst, input logic [6:0] o,
                        input logic [2:0] f3, input logic f7, input logic z,
                        input logic [10:0] exp);
        @(negedge clk);
        rst_n = rst; op = o; funct3 = f3; funct7 = f7; Zero = z;
        @(posedge clk);
        #1;
        check(tag, outs(), exp);
    endtask

    localparam logic [10:0] V_ZERO = 11'b0_0_0_0_00_00_000;
    localparam logic [10:0] V_LW   = 11'b0_0_1_1_00_01_000;
    localparam logic [10:0] V_SW   = 11'b0_1_1_0_01_00_000;
    localparam logic [10:0] V_ADD  = 11'b0_0_0_1_00_00_000;
    localparam logic [10:0] V_SUB  = 11'b0_0_0_1_00_00_001;
    localparam logic [10:0] V_SLT  = 11'b0_0_0_1_00_00_101;
    localparam logic [10:0] V_OR   = 11'b0_0_0_1_00_00_011;
    localparam logic [10:0] V_AND  = 11'b0_0_0_1_00_00_010;
    localparam logic [10:0] V_BT   = 11'b1_0_0_0_10_00_001;
    localparam logic [10:0] V_BN   = 11'b0_0_0_0_10_00_001;
    localparam logic [10:0] V_ADDI = 11'b0_0_1_1_00_00_000;
    localparam logic [10:0] V_SLTI = 11'b0_0_1_1_00_00_101;
    localparam logic [10:0] V_ANDI = 11'b0_0_1_1_00_00_010;
    localparam logic [10:0] V_JAL  = 11'b1_0_0_1_11_10_000;

`ifdef CTRL_BNE_EN
    localparam logic [10:0] V_F1_Z1 = V_BN;
    localparam logic [10:0] V_F1_Z0 = V_BT;
`else
    localparam logic [10:0] V_F1_Z1 = V_BT;
    localparam logic [10:0] V_F1_Z0 = V_BN;
`endif

    initial begin
        rst_n = 1'b0; op = 7'b1101111; funct3 = 3'b000; funct7 = 1'b0; Zero = 1'b0;
        @(posedge clk);
        #1;
        check("reset_initial", outs(), V_ZERO);

        step("reset_with_jal",  1'b0, 7'b1101111, 3'b000, 1'b0, 1'b0, V_ZERO);
        step("jal_after_rel",   1'b1, 7'b1101111, 3'b000, 1'b0, 1'b0, V_JAL);
        step("lw",              1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0, V_LW);
        step("sw",              1'b1, 7'b0100011, 3'b010, 1'b0, 1'b1, V_SW);
        step("r_add",           1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0, V_ADD);
        step("r_sub",           1'b1, 7'b0110011, 3'b000, 1'b1, 1'b0, V_SUB);
        step("r_slt",           1'b1, 7'b0110011, 3'b010, 1'b0, 1'b0, V_SLT);
        step("r_or",            1'b1, 7'b0110011, 3'b110, 1'b0, 1'b0, V_OR);
        step("r_and",           1'b1, 7'b0110011, 3'b111, 1'b0, 1'b0, V_AND);
        step("r_f3_001",        1'b1, 7'b0110011, 3'b001, 1'b1, 1'b0, V_ADD);
        step("beq_z1",          1'b1, 7'b1100011, 3'b000, 1'b0, 1'b1, V_BT);
        step("beq_z0",          1'b1, 7'b1100011, 3'b000, 1'b0, 1'b0, V_BN);
        step("br_f3_001_z1",    1'b1, 7'b1100011, 3'b001, 1'b0, 1'b1, V_F1_Z1);
        step("br_f3_001_z0",    1'b1, 7'b1100011, 3'b001, 1'b0, 1'b0, V_F1_Z0);
        step("addi_f7",         1'b1, 7'b0010011, 3'b000, 1'b1, 1'b0, V_ADDI);
        step("slti",            1'b1, 7'b0010011, 3'b010, 1'b0, 1'b0, V_SLTI);
        step("andi",            1'b1, 7'b0010011, 3'b111, 1'b0, 1'b0, V_ANDI);
        step("jal_z1",          1'b1, 7'b1101111, 3'b000, 1'b0, 1'b1, V_JAL);
        step("illegal_7f",      1'b1, 7'b1111111, 3'b000, 1'b1, 1'b1, V_ZERO);
        step("lw_before_rst",   1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0, V_LW);
        step("reset_midstream", 1'b0, 7'b0100011, 3'b000, 1'b0, 1'b1, V_ZERO);
        step("sw_after_rel",    1'b1, 7'b0100011, 3'b000, 1'b0, 1'b1, V_SW);
        step("illegal_00",      1'b1, 7'b0000000, 3'b111, 1'b1, 1'b1, V_ZERO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ctrl.md
CTRL -- requirements
Module: ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 op  input  7  instruction opcode field, bits [6:0].
REQ-005 funct3  input  3  instruction funct3 field.
REQ-006 funct7  input  1  instruction bit 30; selects SUB for R-type.
REQ-007 Zero  input  1  ALU zero flag for the current instruction.
REQ-008 PCSrc  output  1  1 = take branch or jump target; 0 = PC+4.
REQ-009 MemWrite  output  1  data-memory write enable.
REQ-010 ALUSrc  output  1  ALU operand B: 0 = register, 1 = immediate.
REQ-011 RegWrite  output  1  register-file write enable.
REQ-012 ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-013 ResultSrc  output  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
REQ-014 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.

Function
REQ-015 All outputs SHALL be registered; on each rising clk with rst_n=1 they take the decode of the op/funct3/funct7/Zero values present at that edge. Latency is one cycle, with no handshake.
REQ-016 The main decoder SHALL produce the following values, listed as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump:
- lw 0000011: 1, 00, 1, 0, 01, 0, 00, 0
- sw 0100011: 0, 01, 1, 1, 00, 0, 00, 0
- R-type 0110011: 1, 00, 0, 0, 00, 0, 10, 0
- beq 1100011: 0, 10, 0, 0, 00, 1, 01, 0
- I-ALU 0010011: 1, 00, 1, 0, 00, 0, 10, 0
- jal 1101111: 1, 11, 0, 0, 10, 0, 00, 1
REQ-017 Any other opcode SHALL decode all signals to 0, so that no register write, memory write or PC redirect occurs.
REQ-018 PCSrc SHALL equal (Branch AND branch-condition) OR Jump; the branch-condition is Zero unless REQ-024 applies.
REQ-019 ALU decoder for ALUOp=00 SHALL give 000, and for ALUOp=01 SHALL give 001.
REQ-020 ALU decoder for ALUOp=10 SHALL map funct3 as follows: 000 gives 001 if (op[5] AND funct7), else 000; 010 gives 101; 110 gives 011; 111 gives 010; any other funct3 gives 000.
REQ-021 For I-ALU instructions (op[5]=0), funct3=000 SHALL give 000 regardless of funct7 (addi never subtracts).
REQ-022 Internal signals Branch, Jump and ALUOp SHALL NOT be ports.

Reset
REQ-023 When rst_n=0 at a rising clk, every output SHALL become 0 on that edge; this includes reset asserted mid-stream, and inputs are ignored during reset. The first decode follows the first edge with rst_n=1.

Configuration
REQ-024 When macro CTRL_BNE_EN is defined, the branch opcode with funct3=001 (bne) SHALL use NOT Zero as branch-condition, and funct3=000 SHALL use Zero. When the macro is undefined, all branch-opcode encodings SHALL use Zero.

Structure
REQ-025 Package ctrl_pkg SHALL hold the opcode constants and the ImmSrc, ResultSrc, ALUOp and ALUControl encodings as typedef enums.
REQ-026 The ALU decoder SHALL be a combinational sub-module named alu_dec (inputs ALUOp, funct3, funct7, op5; output ALUControl); main decode and the output registers SHALL live in ctrl.

Verification
REQ-027 lw: op=0000011, Zero=0, one clk -> RegWrite=1, ImmSrc=00, ALUSrc=1, MemWrite=0, ResultSrc=01, PCSrc=0.
REQ-028 sw: op=0100011 -> RegWrite=0, ImmSrc=01, ALUSrc=1, MemWrite=1, PCSrc=0.
REQ-029 jal with Zero=0 -> RegWrite=1, ImmSrc=11, MemWrite=0, ResultSrc=10, PCSrc=1.
REQ-030 beq: op=1100011 with Zero=1 -> RegWrite=0, ImmSrc=10, ALUSrc=0, PCSrc=1; with Zero=0 -> PCSrc=0. With CTRL_BNE_EN and funct3=001, the results are inverted.
REQ-031 addi: op=0010011, funct3=000, funct7=1 -> ALUControl=000, ALUSrc=1, ResultSrc=00. R-type op=0110011, funct3=000, funct7=1 -> ALUControl=001.
REQ-032 Reset: drive the jal inputs and hold rst_n=0 for one clk -> all outputs 0. Release rst_n -> jal outputs appear one edge later. Illegal op 1111111 -> all outputs 0.
